// File: rtl/icache.sv
// Direct-mapped instruction cache with multi-word lines in front of a read-only instruction ROM.
// Hits are served combinationally in the fetch cycle. A miss stalls the pipeline while a
// sequential FSM refills the whole line, one word per ROM_LAT cycles. fence.i invalidation
// is supported through flush_i.
module icache #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned INDEX_W  = 6,
    parameter int unsigned OFFSET_W = 2,
    parameter int unsigned ROM_LAT  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_ce_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    input  logic              flush_i,
    output logic [DATA_W-1:0] if_inst_o,
    output logic              stallreq_o,
    output logic              rom_ce_o,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [DATA_W-1:0] rom_data_i
);

    localparam int unsigned TAG_W  = ADDR_W - INDEX_W - OFFSET_W - 2;
    localparam int unsigned LINES  = 1 << INDEX_W;
    localparam int unsigned WORDS  = 1 << OFFSET_W;
    localparam int unsigned LAT_W  = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;

    localparam logic [LAT_W-1:0]    LAT_LAST  = LAT_W'(ROM_LAT - 1);
    localparam logic [OFFSET_W-1:0] WORD_LAST = '1;

    typedef enum logic [0:0] {
        StIdle,
        StRefill
    } state_e;

    // Control state (asynchronously reset)
    state_e              state_q;
    logic [LINES-1:0]    valid_q;
    logic [TAG_W-1:0]    miss_tag_q;
    logic [INDEX_W-1:0]  miss_index_q;
    logic [OFFSET_W-1:0] word_cnt_q;
    logic [LAT_W-1:0]    lat_cnt_q;
    logic                flush_pending_q;
    logic                rom_ce_q;
    logic [ADDR_W-1:0]   rom_addr_q;

    // Line storage; contents are meaningless until the matching valid bit is set
    logic [TAG_W-1:0]    tag_mem  [LINES];
    logic [DATA_W-1:0]   data_mem [LINES*WORDS];

    // Request address fields
    logic [OFFSET_W-1:0] req_offset;
    logic [INDEX_W-1:0]  req_index;
    logic [TAG_W-1:0]    req_tag;

    assign req_offset = if_addr_i[OFFSET_W+1:2];
    assign req_index  = if_addr_i[INDEX_W+OFFSET_W+1:OFFSET_W+2];
    assign req_tag    = if_addr_i[ADDR_W-1:INDEX_W+OFFSET_W+2];

    // Byte offset within a word is irrelevant for word-aligned instruction fetch
    logic unused_byte_off;
    assign unused_byte_off = ^if_addr_i[1:0];

    logic                in_idle;
    logic                in_refill;
    logic                hit;
    logic                miss;
    logic                flush_idle;
    logic                word_done;
    logic                refill_last;
    logic [OFFSET_W-1:0] word_nxt;

    // Lookup and refill progress decode
    always_comb begin
        in_idle     = (state_q == StIdle);
        in_refill   = (state_q == StRefill);
        hit         = in_idle && if_ce_i && valid_q[req_index] && (tag_mem[req_index] == req_tag);
        flush_idle  = in_idle && flush_i;
        // A flush in the same cycle takes priority over starting a refill
        miss        = in_idle && if_ce_i && !hit && !flush_i;
        word_done   = in_refill && (lat_cnt_q == LAT_LAST);
        refill_last = word_done && (word_cnt_q == WORD_LAST);
        word_nxt    = word_cnt_q + 1'b1;
    end

    // Fetch-side outputs; stall is forced low while reset is held
    always_comb begin
        stallreq_o = rst && (flush_idle || miss || in_refill);
        if_inst_o  = '0;
        if (hit && !flush_i) begin
            if_inst_o = data_mem[{req_index, req_offset}];
        end
    end

    assign rom_ce_o   = rom_ce_q;
    assign rom_addr_o = rom_addr_q;

    // Refill FSM with registered ROM interface and valid-bit maintenance
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= StIdle;
            valid_q         <= '0;
            miss_tag_q      <= '0;
            miss_index_q    <= '0;
            word_cnt_q      <= '0;
            lat_cnt_q       <= '0;
            flush_pending_q <= 1'b0;
            rom_ce_q        <= 1'b0;
            rom_addr_q      <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (flush_i) begin
                        valid_q <= '0;
                    end else if (miss) begin
                        miss_tag_q   <= req_tag;
                        miss_index_q <= req_index;
                        word_cnt_q   <= '0;
                        lat_cnt_q    <= '0;
                        rom_ce_q     <= 1'b1;
                        rom_addr_q   <= {req_tag, req_index, {OFFSET_W{1'b0}}, 2'b00};
                        state_q      <= StRefill;
                    end
                end
                StRefill: begin
                    if (flush_i) begin
                        flush_pending_q <= 1'b1;
                    end
                    if (word_done) begin
                        lat_cnt_q  <= '0;
                        word_cnt_q <= word_nxt;
                        if (word_cnt_q == WORD_LAST) begin
                            // A flush seen at any point of the refill discards every line,
                            // including the one just fetched
                            if (flush_pending_q || flush_i) begin
                                valid_q <= '0;
                            end else begin
                                valid_q[miss_index_q] <= 1'b1;
                            end
                            flush_pending_q <= 1'b0;
                            rom_ce_q        <= 1'b0;
                            rom_addr_q      <= '0;
                            state_q         <= StIdle;
                        end else begin
                            rom_addr_q <= {miss_tag_q, miss_index_q, word_nxt, 2'b00};
                        end
                    end else begin
                        lat_cnt_q <= lat_cnt_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Tag and data arrays are written only by the refill, never reset
    always_ff @(posedge clk) begin
        if (word_done) begin
            data_mem[{miss_index_q, word_cnt_q}] <= rom_data_i;
        end
        if (refill_last) begin
            tag_mem[miss_index_q] <= miss_tag_q;
        end
    end

endmodule
